// File: rtl/ntt_pkg.sv
// Shared types and default sizing for the NTT address/control scheduler.
package ntt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_SCALE,
        ST_SDRAIN,
        ST_DONE
    } state_t;

    localparam logic MODE_NTT  = 1'b0;   // forward, Cooley-Tukey
    localparam logic MODE_INTT = 1'b1;   // inverse, Gentleman-Sande

    localparam int DEF_LOG_N  = 8;
    localparam int DEF_DW     = 24;
    localparam int DEF_BF_LAT = 3;

endpackage

// File: rtl/ntt_wb_delay.sv
// Write-back delay line: carries a butterfly's valid and operand addresses
// through LAT registers so the write lands when the butterfly result does.
module ntt_wb_delay #(
    parameter int LAT = 3,
    parameter int AW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [AW-1:0] in_a0,
    input  logic [AW-1:0] in_a1,
    output logic          out_vld,
    output logic [AW-1:0] out_a0,
    output logic [AW-1:0] out_a1
);

    logic [LAT:1]         vld_pipe;
    logic [LAT:1][AW-1:0] a0_pipe;
    logic [LAT:1][AW-1:0] a1_pipe;

    // Clearing the valid bits on reset is what cancels in-flight write-backs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a0_pipe  <= '0;
            a1_pipe  <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            a0_pipe[1]  <= in_a0;
            a1_pipe[1]  <= in_a1;
            for (int k = 2; k <= LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                a0_pipe[k]  <= a0_pipe[k-1];
                a1_pipe[k]  <= a1_pipe[k-1];
            end
        end
    end

    assign out_vld = vld_pipe[LAT];
    assign out_a0  = a0_pipe[LAT];
    assign out_a1  = a1_pipe[LAT];

endmodule

// File: rtl/ntt_sched.sv
// NTT/INTT butterfly scheduler: operand/twiddle addressing, delayed write-back
// and a load window. Define NTT_SCALE_EN to add the inverse scaling pass.
module ntt_sched
    import ntt_pkg::*;
#(
    parameter int LOG_N  = DEF_LOG_N,
    parameter int DW     = DEF_DW,
    parameter int BF_LAT = DEF_BF_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             load_mem,
    input  logic [15:0]      A_load,
    input  logic [DW-1:0]    D_load,
    input  logic             WEB_load,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr0,
    output logic [LOG_N-1:0] rd_addr1,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr0,
    output logic [LOG_N-1:0] wr_addr1,
    output logic             wr_sel,
    output logic [DW-1:0]    ld_wdata,
    output logic [LOG_N-1:0] tw_addr,
    output logic             bf_mode,
    output logic             scale_en,
    output logic             load_err
);

    localparam int N  = 1 << LOG_N;
    localparam int BW = LOG_N - 1;
    localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

    localparam logic [BW-1:0] B_LAST = {BW{1'b1}};
    localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);
    localparam logic [3:0]    D_LAST = 4'(BF_LAT - 1);

`ifdef NTT_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    state_t           state;
    logic [BW-1:0]    b;
    logic [SW-1:0]    s;
    logic [3:0]       dcnt;
    logic             mode_q;
    logic             ld_we;
    logic [LOG_N-1:0] ld_addr;
    logic             scale_q;

    logic [SW-1:0]    lg;
    logic [LOG_N-1:0] bx, grp, msk, a0_c, a1_c, tw_c;

    logic             dly_vld;
    logic [LOG_N-1:0] dly_a0, dly_a1;

    // len is a power of two, so group/offset reduce to shifts and masks.
    // The inverse twiddle wraps N to 0 at s=0, which still yields N-1-group.
    always_comb begin
        lg   = (mode_q == MODE_INTT) ? s : S_LAST - s;
        bx   = {1'b0, b};
        grp  = bx >> lg;
        msk  = (LOG_N'(1) << lg) - LOG_N'(1);
        a0_c = ((grp << lg) << 1) | (bx & msk);
        a1_c = a0_c | (LOG_N'(1) << lg);
        if (mode_q == MODE_INTT)
            tw_c = LOG_N'(N >> s) - LOG_N'(1) - grp;
        else
            tw_c = (LOG_N'(1) << s) + grp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            b        <= '0;
            s        <= '0;
            dcnt     <= '0;
            mode_q   <= MODE_NTT;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            tw_addr  <= '0;
            ld_we    <= 1'b0;
            ld_addr  <= '0;
            ld_wdata <= '0;
            load_err <= 1'b0;
            scale_q  <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_en    <= 1'b0;
            ld_we    <= 1'b0;
            scale_q  <= 1'b0;
            ld_wdata <= D_load;
            if (load_mem && !WEB_load && state != ST_IDLE)
                load_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    ld_we   <= load_mem & ~WEB_load;
                    ld_addr <= A_load[LOG_N-1:0];
                    if (start && !load_mem) begin
                        mode_q   <= mode;
                        load_err <= 1'b0;
                        busy     <= 1'b1;
                        b        <= '0;
                        s        <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rd_en    <= 1'b1;
                    rd_addr0 <= a0_c;
                    rd_addr1 <= a1_c;
                    tw_addr  <= tw_c;
                    if (b == B_LAST) begin
                        b     <= '0;
                        dcnt  <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        b <= b + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == D_LAST) begin
                        dcnt <= '0;
                        if (s == S_LAST) begin
                            state <= (SCALE_ON && mode_q == MODE_INTT) ? ST_SCALE : ST_DONE;
                        end else begin
                            s     <= s + 1'b1;
                            state <= ST_RUN;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                ST_SCALE: begin
                    rd_en    <= 1'b1;
                    rd_addr0 <= {b, 1'b0};
                    rd_addr1 <= {b, 1'b1};
                    tw_addr  <= '0;
                    scale_q  <= 1'b1;
                    if (b == B_LAST) begin
                        b     <= '0;
                        dcnt  <= '0;
                        state <= ST_SDRAIN;
                    end else begin
                        b <= b + 1'b1;
                    end
                end
                ST_SDRAIN: begin
                    if (dcnt == D_LAST) begin
                        dcnt  <= '0;
                        state <= ST_DONE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ntt_wb_delay #(
        .LAT (BF_LAT),
        .AW  (LOG_N)
    ) u_wb_delay (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_en),
        .in_a0   (rd_addr0),
        .in_a1   (rd_addr1),
        .out_vld (dly_vld),
        .out_a0  (dly_a0),
        .out_a1  (dly_a1)
    );

    // Loads only happen in IDLE, when the delay line has long since emptied.
    assign wr_en    = ld_we | dly_vld;
    assign wr_sel   = ld_we;
    assign wr_addr0 = ld_we ? ld_addr : dly_a0;
    assign wr_addr1 = ld_we ? '0 : dly_a1;
    assign bf_mode  = mode_q;

`ifdef NTT_SCALE_EN
    assign scale_en = scale_q;
`else
    assign scale_en = 1'b0;
    wire unused_scale = scale_q;
`endif

    wire unused_aload = &{1'b0, A_load[15:LOG_N]};

endmodule

// File: tb/tb_ntt_sched.sv
// Scoreboard bench for ntt_sched: default instance plus a LOG_N=4/BF_LAT=1 instance.
module tb_ntt_sched;

    localparam int LN = 8, LAT = 3;
    localparam int LNB = 4, LATB = 1;
`ifdef NTT_SCALE_EN
    localparam int DONE_INV = 1180, SC_EXP = 128;
`else
    localparam int DONE_INV = 1049, SC_EXP = 0;
`endif

    typedef struct {int cyc; int a0; int a1; int tw; int sc;} rd_t;
    typedef struct {int cyc; int sel; int a0; int a1; int d;} wr_t;

    logic clk, rst, start, mode, load_mem, WEB_load;
    logic [15:0] A_load;
    logic [23:0] D_load;
    logic busy, done, rd_en, wr_en, wr_sel, bf_mode, scale_en, load_err;
    logic [LN-1:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1, tw_addr;
    logic [23:0] ld_wdata;

    logic start_b, lm_b, web_b;
    logic [15:0] al_b;
    logic [23:0] dl_b;
    logic busy_b, done_b, rd_en_b, wr_en_b, wr_sel_b, bfm_b, sc_b, lerr_b;
    logic [LNB-1:0] rd0_b, rd1_b, wr0_b, wr1_b, tw_b;
    logic [23:0] ldw_b;

    int cyc = 0, errors = 0, checks = 0, sc_cnt = 0, e0;
    rd_t rdq[$], rdqb[$];
    wr_t wrq[$], wrqb[$];
    int doneq[$], doneqb[$];
    rd_t mr, mrb;
    wr_t mw, mwb;
    int d;

    ntt_sched dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .load_mem(load_mem),
        .A_load(A_load), .D_load(D_load), .WEB_load(WEB_load),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_sel(wr_sel),
        .ld_wdata(ld_wdata), .tw_addr(tw_addr), .bf_mode(bf_mode), .scale_en(scale_en),
        .load_err(load_err)
    );

    ntt_sched #(.LOG_N(LNB), .DW(24), .BF_LAT(LATB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(1'b0), .load_mem(lm_b),
        .A_load(al_b), .D_load(dl_b), .WEB_load(web_b),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_addr0(rd0_b), .rd_addr1(rd1_b),
        .wr_en(wr_en_b), .wr_addr0(wr0_b), .wr_addr1(wr1_b), .wr_sel(wr_sel_b),
        .ld_wdata(ldw_b), .tw_addr(tw_b), .bf_mode(bfm_b), .scale_en(sc_b),
        .load_err(lerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: cyc=%0d got %0d expected %0d", nm, cyc, act, exp);
        end
    endfunction

    // Expected schedule straight from the len/group/twiddle definitions.
    task automatic gen_ntt(input int dut_id, input int logn, input int lat, input int md, input int st);
        int n, h, len, grp, a0, tw, c, tot;
        n = 1 << logn;
        h = n / 2;
        for (int s = 0; s < logn; s++)
            for (int b = 0; b < h; b++) begin
                len = md ? (1 << s) : (n >> (s + 1));
                grp = b / len;
                a0  = 2 * len * grp + b % len;
                tw  = md ? (n >> s) - 1 - grp : (1 << s) + grp;
                c   = st + 1 + s * (h + lat) + b;
                if (dut_id == 0) begin
                    rdq.push_back('{c, a0, a0 + len, tw, 0});
                    wrq.push_back('{c + lat, 0, a0, a0 + len, -1});
                end else begin
                    rdqb.push_back('{c, a0, a0 + len, tw, 0});
                    wrqb.push_back('{c + lat, 0, a0, a0 + len, -1});
                end
            end
        tot = st + 1 + logn * (h + lat);
`ifdef NTT_SCALE_EN
        if (md && dut_id == 0) begin
            for (int i = 0; i < h; i++) begin
                rdq.push_back('{tot + i, 2 * i, 2 * i + 1, 0, 1});
                wrq.push_back('{tot + i + lat, 0, 2 * i, 2 * i + 1, -1});
            end
            tot = tot + h + lat;
        end
`endif
        if (dut_id == 0) doneq.push_back(tot);
        else doneqb.push_back(tot);
    endtask

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic do_start(input logic md);
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        @(posedge clk);
        #1 e0 = cyc;
        gen_ntt(0, LN, LAT, int'(md), e0);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (scale_en === 1'b1) sc_cnt++;
        if (rd_en === 1'b1) begin
            checks++;
            if (rdq.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: cyc=%0d a0=%0d a1=%0d", cyc, rd_addr0, rd_addr1);
            end else begin
                mr = rdq.pop_front();
                if (cyc != mr.cyc || int'(rd_addr0) != mr.a0 || int'(rd_addr1) != mr.a1 ||
                    int'(tw_addr) != mr.tw || int'(scale_en) != mr.sc) begin
                    errors++;
                    $display("FAIL rd: got cyc=%0d a0=%0d a1=%0d tw=%0d sc=%0d expected cyc=%0d a0=%0d a1=%0d tw=%0d sc=%0d",
                             cyc, rd_addr0, rd_addr1, tw_addr, scale_en, mr.cyc, mr.a0, mr.a1, mr.tw, mr.sc);
                end
            end
        end
        if (wr_en === 1'b1) begin
            checks++;
            if (wrq.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: cyc=%0d sel=%0d a0=%0d", cyc, wr_sel, wr_addr0);
            end else begin
                mw = wrq.pop_front();
                if (cyc != mw.cyc || int'(wr_sel) != mw.sel || int'(wr_addr0) != mw.a0 ||
                    (mw.a1 >= 0 && int'(wr_addr1) != mw.a1) || (mw.d >= 0 && int'(ld_wdata) != mw.d)) begin
                    errors++;
                    $display("FAIL wr: got cyc=%0d sel=%0d a0=%0d a1=%0d d=%0d expected cyc=%0d sel=%0d a0=%0d a1=%0d d=%0d",
                             cyc, wr_sel, wr_addr0, wr_addr1, ld_wdata, mw.cyc, mw.sel, mw.a0, mw.a1, mw.d);
                end
            end
        end
        if (done === 1'b1) begin
            if (doneq.size() == 0) chk("done_unexpected", cyc, -1);
            else chk("done_cycle", cyc, doneq.pop_front());
        end
    end

    // Monitor for the small instance.
    always @(negedge clk) begin
        if (rd_en_b === 1'b1) begin
            checks++;
            if (rdqb.size() == 0) begin
                errors++;
                $display("FAIL rd_b_unexpected: cyc=%0d a0=%0d", cyc, rd0_b);
            end else begin
                mrb = rdqb.pop_front();
                if (cyc != mrb.cyc || int'(rd0_b) != mrb.a0 || int'(rd1_b) != mrb.a1 || int'(tw_b) != mrb.tw) begin
                    errors++;
                    $display("FAIL rd_b: got cyc=%0d a0=%0d a1=%0d tw=%0d expected cyc=%0d a0=%0d a1=%0d tw=%0d",
                             cyc, rd0_b, rd1_b, tw_b, mrb.cyc, mrb.a0, mrb.a1, mrb.tw);
                end
            end
        end
        if (wr_en_b === 1'b1) begin
            checks++;
            if (wrqb.size() == 0) begin
                errors++;
                $display("FAIL wr_b_unexpected: cyc=%0d a0=%0d", cyc, wr0_b);
            end else begin
                mwb = wrqb.pop_front();
                if (cyc != mwb.cyc || int'(wr_sel_b) != 0 || int'(wr0_b) != mwb.a0 || int'(wr1_b) != mwb.a1) begin
                    errors++;
                    $display("FAIL wr_b: got cyc=%0d sel=%0d a0=%0d a1=%0d expected cyc=%0d a0=%0d a1=%0d",
                             cyc, wr_sel_b, wr0_b, wr1_b, mwb.cyc, mwb.a0, mwb.a1);
                end
            end
        end
        if (done_b === 1'b1) begin
            if (doneqb.size() == 0) chk("done_b_unexpected", cyc, -1);
            else chk("done_b_cycle", cyc, doneqb.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete at cyc=%0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; load_mem = 1'b0; WEB_load = 1'b1;
        A_load = '0; D_load = '0;
        start_b = 1'b0; lm_b = 1'b0; web_b = 1'b1; al_b = '0; dl_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(|{busy, done, rd_en, rd_addr0, rd_addr1, wr_en, wr_addr0, wr_addr1,
                                   wr_sel, ld_wdata, tw_addr, bf_mode, scale_en, load_err}), 0);
        chk("reset_outputs_b", int'(|{busy_b, done_b, rd_en_b, wr_en_b, wr_sel_b, lerr_b}), 0);
        rst = 1'b0;

        // Load window: 256 writes, then a distinct data word and two non-writes.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            load_mem = 1'b1; WEB_load = 1'b0; A_load = 16'(i); D_load = 24'(i);
            wrq.push_back('{cyc + 1, 1, i, -1, i});
        end
        @(negedge clk);
        A_load = 16'h0103; D_load = 24'h5A5A5A;
        wrq.push_back('{cyc + 1, 1, 3, -1, 24'h5A5A5A});
        @(negedge clk);
        WEB_load = 1'b1; A_load = 16'd9;
        @(negedge clk);
        load_mem = 1'b0; WEB_load = 1'b0;
        @(negedge clk);
        WEB_load = 1'b1; A_load = '0; D_load = '0;
        repeat (3) @(negedge clk);

        // Forward transform with a start+load collision mid-run.
        do_start(1'b0);
        chk("fwd_busy_c0", int'(busy), 1);
        chk("fwd_bf_mode", int'(bf_mode), 0);
        wait_cyc(e0 + 1);
        chk("fwd_first_a0", int'(rd_addr0), 0);
        chk("fwd_first_a1", int'(rd_addr1), 128);
        chk("fwd_first_tw", int'(tw_addr), 1);
        wait_cyc(e0 + 499);
        start = 1'b1; load_mem = 1'b1; WEB_load = 1'b0; A_load = 16'd5; D_load = 24'd77;
        wait_cyc(e0 + 500);
        start = 1'b0; load_mem = 1'b0; WEB_load = 1'b1; A_load = '0; D_load = '0;
        chk("load_err_set", int'(load_err), 1);
        wait_cyc(e0 + 1045);
        chk("fwd_last_a0", int'(rd_addr0), 254);
        chk("fwd_last_a1", int'(rd_addr1), 255);
        chk("fwd_last_tw", int'(tw_addr), 255);
        wait_cyc(e0 + 1048);
        chk("fwd_busy_before_done", int'(busy), 1);
        wait_cyc(e0 + 1049);
        chk("fwd_done", int'(done), 1);
        chk("fwd_busy_at_done", int'(busy), 0);
        wait_cyc(e0 + 1055);
        chk("load_err_sticky", int'(load_err), 1);
        chk("fwd_idle_busy", int'(busy), 0);

        // Inverse transform.
        sc_cnt = 0;
        do_start(1'b1);
        chk("inv_load_err_clr", int'(load_err), 0);
        chk("inv_bf_mode", int'(bf_mode), 1);
        wait_cyc(e0 + 1);
        chk("inv_first_a0", int'(rd_addr0), 0);
        chk("inv_first_a1", int'(rd_addr1), 1);
        chk("inv_first_tw", int'(tw_addr), 255);
        wait_cyc(e0 + 1045);
        chk("inv_last_a0", int'(rd_addr0), 127);
        chk("inv_last_a1", int'(rd_addr1), 255);
        chk("inv_last_tw", int'(tw_addr), 1);
        wait_cyc(e0 + DONE_INV);
        chk("inv_done", int'(done), 1);
        chk("inv_busy_at_done", int'(busy), 0);
        chk("inv_scale_cycles", sc_cnt, SC_EXP);
        repeat (4) @(negedge clk);

        // Reset in the middle of a forward transform.
        do_start(1'b0);
        wait_cyc(e0 + 299);
        #1 rst = 1'b1;
        while (rdq.size() > 0 && rdq[rdq.size() - 1].cyc > e0 + 299) void'(rdq.pop_back());
        while (wrq.size() > 0 && wrq[wrq.size() - 1].cyc > e0 + 299) void'(wrq.pop_back());
        doneq.delete();
        wait_cyc(e0 + 300);
        chk("rst_mid_outputs", int'(|{busy, done, rd_en, rd_addr0, rd_addr1, wr_en, wr_addr0, wr_addr1,
                                     wr_sel, ld_wdata, tw_addr, bf_mode, scale_en, load_err}), 0);
        rst = 1'b0;
        d = 0;
        repeat (10) begin
            @(negedge clk);
            if (wr_en === 1'b1) d++;
        end
        chk("rst_no_wr", d, 0);
        do_start(1'b0);
        wait_cyc(e0 + 1049);
        chk("post_rst_done", int'(done), 1);
        repeat (4) @(negedge clk);

        // Small configuration.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        gen_ntt(1, LNB, LATB, 0, e0);
        @(negedge clk);
        start_b = 1'b0;
        chk("b_busy_c0", int'(busy_b), 1);
        wait_cyc(e0 + 36);
        chk("b_busy_before_done", int'(busy_b), 1);
        wait_cyc(e0 + 37);
        chk("b_done", int'(done_b), 1);
        repeat (6) @(negedge clk);

        chk("rdq_empty", rdq.size(), 0);
        chk("wrq_empty", wrq.size(), 0);
        chk("doneq_empty", doneq.size(), 0);
        chk("rdqb_empty", rdqb.size(), 0);
        chk("wrqb_empty", wrqb.size(), 0);
        chk("doneqb_empty", doneqb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
